init_profile_gen: RTL and testbench
===================================

INIT_PROFILE_GEN -- requirements
Module: init_profile_gen

Interface
REQ-001 SHALL have parameter N_NODES, default 30, the number of nodes in one profile (legal range 3..1024).
REQ-002 SHALL have parameter DATA_W, default 18, the node value width (unsigned).
REQ-003 SHALL have parameter PEAK, default 18'h08000, the apex value, required to be < 2^DATA_W.
REQ-004 SHALL have derived localparam ADDR_W = $clog2(N_NODES).
REQ-005 SHALL have ports: clk in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start in 1, begin profile; abort in 1, cancel profile.
REQ-007 SHALL have ports: busy out 1, profile in progress; done out 1, one-cycle completion pulse.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_addr out ADDR_W; out_data out DATA_W.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE.
REQ-010 SHALL, in IDLE with start=1 at edge t, enter RUN with out_valid=1, out_addr=0 from t+1.
REQ-011 SHALL set out_data for node i to floor(PEAK*k/M), where k=min(i, N_NODES-1-i) and M=floor((N_NODES-1)/2).
REQ-012 SHALL make node 0 and node N_NODES-1 equal 0; for even N_NODES, nodes M and M+1 both equal PEAK.
REQ-013 SHALL compute values incrementally with a quotient/remainder accumulator (Q=PEAK/M, R=PEAK%M fixed at elaboration); no runtime divider or multiplier.
REQ-014 SHALL advance to the next node on the cycle after out_valid&&out_ready; one node per cycle when out_ready is held at 1.
REQ-015 SHALL hold out_addr and out_data stable while out_valid&&!out_ready.
REQ-016 SHALL, after acceptance of node N_NODES-1, drop out_valid and enter DONE; done=1 for exactly that one cycle, then return to IDLE.
REQ-017 SHALL hold busy=1 in RUN only.
REQ-018 SHALL ignore start while in RUN or DONE.
REQ-019 SHALL give abort priority over start and transfer: abort in RUN sends the FSM to IDLE next cycle with out_valid=0 and no done pulse.
REQ-020 SHALL treat abort in IDLE or DONE as no effect.
REQ-021 SHALL prevent out_addr from ever exceeding N_NODES-1.

Reset
REQ-022 SHALL, on reset_n=0, immediately force IDLE, busy=0, done=0, out_valid=0, out_addr=0, out_data=0, and clear the accumulators, including mid-profile.
REQ-023 SHALL, after release of reset_n, require a fresh start before any output.

Configuration
REQ-024 SHALL, with INIT_GEN_SCALE_EN defined, add input scale (DATA_W, unsigned, DATA_W-1 fraction bits; 2^(DATA_W-1)=1.0), latched on accepted start.
REQ-025 SHALL, with INIT_GEN_SCALE_EN defined, output out_data=(raw*scale_latched)>>(DATA_W-1), saturated to 2^DATA_W-1, at unchanged latency.
REQ-026 SHALL, without INIT_GEN_SCALE_EN, omit the scale port and output out_data=raw.

Structure
REQ-027 SHALL place the FSM state enum and the default DATA_W/PEAK constants in shared package drum_pkg.
REQ-028 SHALL use one sub-module, tri_accum, holding the Q/R accumulator with ascend/descend/clear controls.

Verification
REQ-029 SHALL cover defaults, out_ready=1, start pulse: 30 beats on consecutive cycles, addr 0..29, data 0,0x00924,0x01249,...,0x08000,0x08000,...,0x00924,0; then done once and busy low.
REQ-030 SHALL cover N_NODES=31, PEAK=0x3FFFF: node 15=0x3FFFF; node 1=0x04444; node 30=0; profile symmetric.
REQ-031 SHALL cover out_ready toggled pseudo-randomly: each addr/data pair held while stalled; exactly 30 unique accepted beats.
REQ-032 SHALL cover abort at addr 10: out_valid low next cycle, no done; a later start restarts at addr 0.
REQ-033 SHALL cover reset_n low at addr 20: all outputs 0 asynchronously; no output until a new start.
REQ-034 SHALL cover INIT_GEN_SCALE_EN with scale=0x10000 (0.5): node 14=0x04000; with scale=0x3FFFF: node 14=0x0FFFF.

Source files
------------

// File: rtl/drum_pkg.sv
// drum_pkg: shared FSM state type and default profile constants for init_profile_gen
package drum_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_DATA_W = 18;
  localparam logic [DEF_DATA_W-1:0] DEF_PEAK = 18'h08000;
endpackage

// File: rtl/tri_accum.sv
// tri_accum: quotient/remainder accumulator tracking floor(PEAK*k/M) as k steps up or down by one
module tri_accum #(
  parameter int DATA_W = 18,
  parameter int RW = 6,
  parameter int Q = 0,
  parameter int R = 0,
  parameter int M = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              asc,
  input  logic              desc,
  output logic [DATA_W-1:0] q
);
  localparam logic [DATA_W-1:0] QV = DATA_W'(Q);
  localparam logic [DATA_W-1:0] QV1 = DATA_W'(Q + 1);
  localparam logic [RW-1:0] RV = RW'(R);
  localparam logic [RW-1:0] MV = RW'(M);
  logic [RW-1:0] r, r_up;
  logic wrap_up, wrap_dn;
  always_comb begin
    r_up = r + RV;
    wrap_up = r_up >= MV;
    wrap_dn = r < RV;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q <= '0;
      r <= '0;
    end else if (clr) begin
      q <= '0;
      r <= '0;
    end else if (asc) begin
      q <= q + (wrap_up ? QV1 : QV);
      r <= wrap_up ? r_up - MV : r_up;
    end else if (desc) begin
      q <= q - (wrap_dn ? QV1 : QV);
      r <= wrap_dn ? r + MV - RV : r - RV;
    end
endmodule

// File: rtl/init_profile_gen.sv
// init_profile_gen: streams a triangular profile of N_NODES values; INIT_GEN_SCALE_EN adds a latched output scale
module init_profile_gen
  import drum_pkg::*;
#(
  parameter int N_NODES = 30,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PEAK = DEF_PEAK,
  localparam int ADDR_W = $clog2(N_NODES)
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef INIT_GEN_SCALE_EN
  input  logic [DATA_W-1:0] scale,
`endif
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);
  localparam int M = (N_NODES - 1) / 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NODES - 1);
  localparam logic [ADDR_W+1:0] N_UP = (ADDR_W + 2)'(N_NODES - 3);
  localparam logic [ADDR_W+1:0] N_HOLD = (ADDR_W + 2)'(N_NODES - 2);
  state_t state;
  logic accept, fire, last, clr, asc, desc;
  logic [ADDR_W+1:0] a2;
  logic [DATA_W-1:0] raw;
  // k(i+1) vs k(i): rises while 2i+3 <= N, flat at the even-N apex, falls after
  always_comb begin
    accept = state == IDLE && start;
    fire = state == RUN && out_valid && out_ready && !abort;
    last = out_addr == LAST;
    a2 = {1'b0, out_addr, 1'b0};
    clr = accept || (state == RUN && abort) || (fire && last);
    asc = fire && !last && a2 <= N_UP;
    desc = fire && !last && a2 > N_UP && a2 != N_HOLD;
  end
  tri_accum #(
    .DATA_W(DATA_W),
    .RW(ADDR_W + 1),
    .Q(int'(PEAK) / M),
    .R(int'(PEAK) % M),
    .M(M)
  ) u_accum (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .asc(asc),
    .desc(desc),
    .q(raw)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
          out_valid <= 1'b1;
          out_addr <= '0;
        end
        RUN: if (abort || (fire && last)) begin
          state <= abort ? IDLE : DONE;
          done <= !abort;
          busy <= 1'b0;
          out_valid <= 1'b0;
          out_addr <= '0;
        end else if (fire) out_addr <= out_addr + 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef INIT_GEN_SCALE_EN
  logic [DATA_W-1:0] scale_l;
  logic [2*DATA_W-1:0] prod;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) scale_l <= '0;
    else if (accept) scale_l <= scale;
  always_comb begin
    prod = {{DATA_W{1'b0}}, raw} * {{DATA_W{1'b0}}, scale_l};
    out_data = prod[2*DATA_W-1] ? '1 : prod[2*DATA_W-2:DATA_W-1];
  end
`else
  assign out_data = raw;
`endif
endmodule

// File: tb/tb_init_profile_gen.sv
// tb_init_profile_gen: randomized self-checking bench against a triangle reference model
`timescale 1ns/1ps
module tb_init_profile_gen;
  localparam int N = 30;
  localparam int N2 = 31;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0, start2 = 1'b0;
  logic busy, done, out_valid, busy2, done2, out_valid2;
  logic [4:0] out_addr, out_addr2;
  logic [17:0] out_data, out_data2;
  logic [17:0] scale = 18'h20000;
  logic [17:0] seen[N];
  logic [17:0] seen2[N2];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  init_profile_gen dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef INIT_GEN_SCALE_EN
    .scale(scale),
`endif
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data)
  );
  init_profile_gen #(.N_NODES(N2), .PEAK(18'h3FFFF)) dut2 (
    .clk(clk),
    .reset_n(reset_n),
`ifdef INIT_GEN_SCALE_EN
    .scale(scale),
`endif
    .start(start2),
    .abort(1'b0),
    .busy(busy2),
    .done(done2),
    .out_valid(out_valid2),
    .out_ready(1'b1),
    .out_addr(out_addr2),
    .out_data(out_data2)
  );
  function automatic longint model(input int i, input int n, input longint peak, input longint sc);
    int m = (n - 1) / 2;
    int k = (i < n - 1 - i) ? i : n - 1 - i;
    longint v = peak * k / m;
`ifdef INIT_GEN_SCALE_EN
    v = (v * sc) >> 17;
    if (v > 262143) v = 262143;
`endif
    return v;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic profile(input bit rnd, input int abort_at, input int rst_at);
    int i = 0;
    int cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (i < N) begin
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_run", done, 0);
      check("addr", out_addr, i);
      check("data", out_data, model(i, N, 'h8000, scale));
      if (i == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        repeat (3) begin
          check("abort_valid", out_valid, 0);
          check("abort_done", done, 0);
          check("abort_busy", busy, 0);
          tick();
        end
        return;
      end
      if (i == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
          tick();
          check("rst_idle", out_valid, 0);
        end
        return;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_ready) seen[i] = out_data;
      tick();
      start = 1'b0;
      if (out_ready) i++;
      cyc++;
      if (cyc > 400) begin
        check("timeout", cyc, 0);
        return;
      end
    end
    check("end_valid", out_valid, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_valid", out_valid, 0);
    tick();
    check("idle_after", out_valid, 0);
  endtask
  initial begin
    repeat (3) tick();
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", out_addr, 0);
    check("reset_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_reset_valid", out_valid, 0);
    profile(1'b0, -1, -1);
    check("node1", seen[1], 'h00924);
    check("node2", seen[2], 'h01249);
    check("node14", seen[14], 'h08000);
    check("node15", seen[15], 'h08000);
    check("node28", seen[28], 'h00924);
    check("node29", seen[29], 0);
    profile(1'b1, -1, -1);
    profile(1'b0, 10, -1);
    profile(1'b0, -1, -1);
    profile(1'b1, -1, 20);
    profile(1'b0, -1, -1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int j = 0; j < N2; j++) begin
      check("n31_valid", out_valid2, 1);
      check("n31_addr", out_addr2, j);
      check("n31_data", out_data2, model(j, N2, 'h3FFFF, scale));
      seen2[j] = out_data2;
      tick();
    end
    check("n31_done", done2, 1);
    check("n31_busy", busy2, 0);
    check("n31_node15", seen2[15], 'h3FFFF);
    check("n31_node1", seen2[1], 'h04444);
    check("n31_node30", seen2[30], 0);
    for (int j = 0; j < 15; j++) check("n31_sym", seen2[j], seen2[30 - j]);
`ifdef INIT_GEN_SCALE_EN
    scale = 18'h10000;
    profile(1'b0, -1, -1);
    check("scale_half", seen[14], 'h04000);
    scale = 18'h3FFFF;
    profile(1'b1, -1, -1);
    check("scale_max", seen[14], 'h0FFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
